// File: rtl/mbus_pkg.sv
// Shared types for the Multibus DVMA master: FSM state encoding, completion codes,
// and the write-data lane helper.
package mbus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_RESP   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    ERR_OK       = 2'd0,
    ERR_TIMEOUT  = 2'd1,
    ERR_MISALIGN = 2'd2
  } err_t;

  localparam int CNT_W = 16;

  // Byte transfers always travel on D7-0, so the byte is mirrored onto both lanes.
  function automatic logic [15:0] lane_wdata(input logic word, input logic [15:0] wdata);
    return word ? wdata : {wdata[7:0], wdata[7:0]};
  endfunction

endpackage

// File: rtl/mbus_dvma_master_if.sv
// Command/response handshake plus Multibus P1 pins of the DVMA master.
interface mbus_dvma_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_word;
  logic [19:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic [19:0] p1_adr;
  logic        p1_bhen_n;
  logic        p1_mrdc_n;
  logic        p1_mrwc_n;
  logic [15:0] p1_dat_out;
  logic        p1_dat_oe;
  logic [15:0] p1_dat_in;
  logic        p1_xack_n;

  modport master (
    input  req_valid, req_write, req_word, req_addr, req_wdata,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    output p1_adr, p1_bhen_n, p1_mrdc_n, p1_mrwc_n, p1_dat_out, p1_dat_oe,
    input  p1_dat_in, p1_xack_n
  );

  modport slave (
    output req_valid, req_write, req_word, req_addr, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    input  p1_adr, p1_bhen_n, p1_mrdc_n, p1_mrwc_n, p1_dat_out, p1_dat_oe,
    output p1_dat_in, p1_xack_n
  );
endinterface

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous bit; reset value is a parameter.
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/mbus_dvma_master.sv
// Multibus DVMA master: runs one memory read/write cycle per accepted command
// with programmable setup/hold and an XACK timeout.
//
// state  | meaning
// IDLE   | ready for a command
// SETUP  | address/data driven, waiting T_SETUP clocks before the strobe
// STROBE | MRDC#/MRWC# low, waiting for synchronized XACK# or timeout
// HOLD   | strobe released, holding address/data, waiting for XACK# high
// RESP   | one-clock completion pulse
module mbus_dvma_master
  import mbus_pkg::*;
#(
  parameter int T_SETUP   = 2,
  parameter int T_HOLD    = 1,
  parameter int T_TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,
  mbus_dvma_master_if.master  bus
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             wr_q;
  logic             word_q;
  logic             xack_s;
  logic             accept;
  logic             misalign;
  logic             cnt_zero;

  sync2 #(.RST_VAL(1'b1)) u_xack_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.p1_xack_n),
    .q     (xack_s)
  );

  always_comb begin
    state_nxt     = state;
    accept        = 1'b0;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    misalign      = bus.req_word & bus.req_addr[0];
    cnt_zero      = (cnt == '0);
    case (state)
      ST_IDLE: begin
        bus.req_ready = !reset;
        if (bus.req_valid && !reset) begin
          accept    = 1'b1;
          state_nxt = misalign ? ST_RESP : ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_zero) state_nxt = ST_STROBE;
      end
      ST_STROBE: begin
        if (!xack_s || cnt_zero) state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        // the slave must drop XACK# before we complete, so cycles never overlap
        if (cnt_zero && xack_s) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        bus.rsp_valid = !reset;
        state_nxt     = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt            <= '0;
      wr_q           <= 1'b0;
      word_q         <= 1'b0;
      bus.p1_adr     <= '0;
      bus.p1_bhen_n  <= 1'b1;
      bus.p1_dat_out <= '0;
      bus.p1_dat_oe  <= 1'b0;
      bus.p1_mrdc_n  <= 1'b1;
      bus.p1_mrwc_n  <= 1'b1;
      bus.rsp_rdata  <= '0;
      bus.rsp_err    <= ERR_OK;
    end else begin
      // strobes are registered from the next state so they never glitch
      bus.p1_mrdc_n <= !((state_nxt == ST_STROBE) && !wr_q);
      bus.p1_mrwc_n <= !((state_nxt == ST_STROBE) &&  wr_q);
      case (state)
        ST_IDLE: begin
          if (accept) begin
            bus.rsp_rdata <= '0;
            if (misalign) begin
              bus.rsp_err <= ERR_MISALIGN;
            end else begin
              bus.rsp_err    <= ERR_OK;
              wr_q           <= bus.req_write;
              word_q         <= bus.req_word;
              bus.p1_adr     <= bus.req_addr;
              bus.p1_bhen_n  <= ~bus.req_word;
              bus.p1_dat_out <= bus.req_write ? lane_wdata(bus.req_word, bus.req_wdata) : '0;
              bus.p1_dat_oe  <= bus.req_write;
              cnt            <= CNT_W'(T_SETUP - 1);
            end
          end
        end
        ST_SETUP: begin
          cnt <= cnt_zero ? CNT_W'(T_TIMEOUT - 1) : cnt - CNT_W'(1);
        end
        ST_STROBE: begin
          if (state_nxt == ST_HOLD) begin
            cnt <= CNT_W'(T_HOLD - 1);
            if (!xack_s) begin
              bus.rsp_err <= ERR_OK;
              if (wr_q)        bus.rsp_rdata <= '0;
              else if (word_q) bus.rsp_rdata <= bus.p1_dat_in;
              else             bus.rsp_rdata <= {8'h00, bus.p1_dat_in[7:0]};
            end else begin
              bus.rsp_err   <= ERR_TIMEOUT;
              bus.rsp_rdata <= '0;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_HOLD: begin
          if (!cnt_zero) cnt <= cnt - CNT_W'(1);
          if (state_nxt == ST_RESP) bus.p1_dat_oe <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mbus_dvma_master.sv
// Bench for mbus_dvma_master: directed vector table, randomized commands against a
// cycle-level reference model, and hand sequences for reset and stray XACK.
module tb_mbus_dvma_master;
  import mbus_pkg::*;

  localparam int T_SETUP   = 2;
  localparam int T_HOLD    = 1;
  localparam int T_TIMEOUT = 255;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mbus_dvma_master_if bus();

  mbus_dvma_master #(
    .T_SETUP   (T_SETUP),
    .T_HOLD    (T_HOLD),
    .T_TIMEOUT (T_TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // d_ack: slave drops XACK# after this many strobe-low clocks (0 = never).
  // h_rel: slave releases XACK# after this many strobe-high clocks.
  typedef struct {
    logic        write;
    logic        word;
    logic [19:0] addr;
    logic [15:0] wdata;
    logic [15:0] bus_data;
    int          d_ack;
    int          h_rel;
    logic [1:0]  exp_err;
    logic [15:0] exp_rdata;
    logic [15:0] exp_dat;
  } vec_t;

  function automatic bit acked(input vec_t v);
    return (v.d_ack > 0) && (v.d_ack + 2 <= T_TIMEOUT);
  endfunction

  // Timing model: XACK# crosses two sync flops, then the FSM reacts one clock later.
  function automatic void model_timing(input vec_t v, output int first_low,
                                       output int len, output int rsp_c);
    int hold;
    if (v.word && v.addr[0]) begin
      first_low = 0;
      len       = 0;
      rsp_c     = 1;
    end else begin
      first_low = T_SETUP + 1;
      len       = acked(v) ? v.d_ack + 2 : T_TIMEOUT;
      hold      = acked(v) ? ((v.h_rel + 2 > T_HOLD) ? v.h_rel + 2 : T_HOLD) : T_HOLD;
      rsp_c     = first_low + len + hold;
    end
  endfunction

  function automatic vec_t model_result(input vec_t v);
    vec_t r = v;
    if (v.word && v.addr[0])  r.exp_err = 2'd2;
    else if (acked(v))        r.exp_err = 2'd0;
    else                      r.exp_err = 2'd1;
    if (r.exp_err != 2'd0 || v.write) r.exp_rdata = 16'h0000;
    else if (v.word)                  r.exp_rdata = v.bus_data;
    else                              r.exp_rdata = {8'h00, v.bus_data[7:0]};
    r.exp_dat = v.word ? v.wdata : {v.wdata[7:0], v.wdata[7:0]};
    return r;
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    int   first_low, len, rsp_c;
    int   seen_low, low_cnt, high_cnt, seen_rsp, pulses, wait_c;
    logic got_first, got_rsp;
    logic [1:0]  got_err;
    logic [15:0] got_rdata;
    logic both_low, wrong_strobe, bad_adr, bad_dat, bad_oe, bad_ready;
    logic ready_at_rsp, oe_at_rsp, ready_after;
    logic mis, lo;
    model_timing(v, first_low, len, rsp_c);
    mis = v.word && v.addr[0];
    seen_low = 0; low_cnt = 0; high_cnt = 0; seen_rsp = 0; pulses = 0;
    got_first = 0; got_rsp = 0; got_err = 2'd3; got_rdata = 16'hxxxx;
    both_low = 0; wrong_strobe = 0; bad_adr = 0; bad_dat = 0; bad_oe = 0; bad_ready = 0;
    ready_at_rsp = 1'bx; oe_at_rsp = 1'bx; ready_after = 1'b0;

    wait_c = 0;
    while (bus.req_ready !== 1'b1 && wait_c < 50) begin
      @(negedge clk);
      wait_c++;
    end
    if (wait_c >= 50) check({tag, "_ready_wait"}, 32'(bus.req_ready), 32'd1);

    bus.req_write = v.write;
    bus.req_word  = v.word;
    bus.req_addr  = v.addr;
    bus.req_wdata = v.wdata;
    bus.p1_dat_in = v.bus_data;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    // scramble the command fields so the DUT must have registered them
    bus.req_valid = 1'b0;
    bus.req_write = ~v.write;
    bus.req_word  = ~v.word;
    bus.req_addr  = 20'($urandom);
    bus.req_wdata = 16'($urandom);

    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      if (!bus.p1_mrdc_n && !bus.p1_mrwc_n) both_low = 1;
      if (v.write ? !bus.p1_mrdc_n : !bus.p1_mrwc_n) wrong_strobe = 1;
      if (mis && (!bus.p1_mrdc_n || !bus.p1_mrwc_n)) wrong_strobe = 1;
      lo = !bus.p1_mrdc_n || !bus.p1_mrwc_n;
      if (lo) begin
        low_cnt++;
        if (!got_first) begin got_first = 1; seen_low = c; end
        if (v.d_ack > 0 && low_cnt == v.d_ack) bus.p1_xack_n = 1'b0;
      end else if (got_first && bus.p1_xack_n == 1'b0) begin
        high_cnt++;
        if (high_cnt == v.h_rel) bus.p1_xack_n = 1'b1;
      end
      if (!got_rsp && bus.req_ready !== 1'b0) bad_ready = 1;
      if (!mis && !got_rsp && !bus.rsp_valid) begin
        if (bus.p1_adr !== v.addr || bus.p1_bhen_n !== ~v.word) bad_adr = 1;
        if (v.write && bus.p1_dat_out !== v.exp_dat) bad_dat = 1;
        if (bus.p1_dat_oe !== v.write) bad_oe = 1;
      end
      if (bus.rsp_valid === 1'b1) begin
        pulses++;
        if (!got_rsp) begin
          got_rsp      = 1;
          seen_rsp     = c;
          got_err      = bus.rsp_err;
          got_rdata    = bus.rsp_rdata;
          ready_at_rsp = bus.req_ready;
          oe_at_rsp    = bus.p1_dat_oe;
        end
      end
      if (got_rsp && c == seen_rsp + 1) begin
        ready_after = bus.req_ready;
        break;
      end
    end
    bus.p1_xack_n = 1'b1;

    if (!got_rsp) check({tag, "_rsp_never"}, 32'd0, 32'd1);
    check({tag, "_err"}, 32'(got_err), 32'(v.exp_err));
    if (!v.write) check({tag, "_rdata"}, 32'(got_rdata), 32'(v.exp_rdata));
    check({tag, "_first_strobe_clk"}, 32'(seen_low), 32'(first_low));
    check({tag, "_strobe_len"}, 32'(low_cnt), 32'(len));
    check({tag, "_rsp_clk"}, 32'(seen_rsp), 32'(rsp_c));
    check({tag, "_rsp_pulses"}, 32'(pulses), 32'd1);
    check({tag, "_both_strobes"}, 32'(both_low), 32'd0);
    check({tag, "_wrong_strobe"}, 32'(wrong_strobe), 32'd0);
    check({tag, "_busy_ready"}, 32'(bad_ready), 32'd0);
    check({tag, "_ready_in_resp"}, 32'(ready_at_rsp), 32'd0);
    check({tag, "_ready_after"}, 32'(ready_after), 32'd1);
    if (!mis) begin
      check({tag, "_adr_bhen"}, 32'(bad_adr), 32'd0);
      check({tag, "_dat_oe"}, 32'(bad_oe), 32'd0);
      check({tag, "_oe_in_resp"}, 32'(oe_at_rsp), 32'd0);
      if (v.write) check({tag, "_dat_out"}, 32'(bad_dat), 32'd0);
    end
  endtask

  vec_t tbl[9];

  initial begin
    vec_t v;
    int   wait_c;
    logic flag;

    //        wr    word  addr        wdata     bus_data  d  h  err   rdata     dat
    tbl[0] = '{1'b0, 1'b1, 20'h01234, 16'h0000, 16'hBEEF, 3, 1, 2'd0, 16'hBEEF, 16'h0000};
    tbl[1] = '{1'b1, 1'b0, 20'h00011, 16'h0055, 16'h0000, 2, 1, 2'd0, 16'h0000, 16'h5555};
    tbl[2] = '{1'b1, 1'b1, 20'h00003, 16'h1234, 16'h0000, 2, 1, 2'd2, 16'h0000, 16'h1234};
    tbl[3] = '{1'b0, 1'b1, 20'h00100, 16'h0000, 16'h1111, 0, 1, 2'd1, 16'h0000, 16'h0000};
    tbl[4] = '{1'b0, 1'b1, 20'h00200, 16'h0000, 16'hCAFE, 2, 5, 2'd0, 16'hCAFE, 16'h0000};
    tbl[5] = '{1'b0, 1'b0, 20'h00011, 16'h0000, 16'hA5C3, 1, 1, 2'd0, 16'h00C3, 16'h0000};
    tbl[6] = '{1'b1, 1'b1, 20'h0FFFE, 16'h8001, 16'h0000, 4, 2, 2'd0, 16'h0000, 16'h8001};
    tbl[7] = '{1'b0, 1'b0, 20'h00010, 16'h0000, 16'h3C7E, 6, 3, 2'd0, 16'h007E, 16'h0000};
    tbl[8] = '{1'b0, 1'b1, 20'h00001, 16'h0000, 16'h4444, 2, 1, 2'd2, 16'h0000, 16'h0000};

    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_word  = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.p1_dat_in = '0;
    bus.p1_xack_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mrdc_n", 32'(bus.p1_mrdc_n), 32'd1);
    check("rst_mrwc_n", 32'(bus.p1_mrwc_n), 32'd1);
    check("rst_bhen_n", 32'(bus.p1_bhen_n), 32'd1);
    check("rst_adr", 32'(bus.p1_adr), 32'd0);
    check("rst_dat_oe", 32'(bus.p1_dat_oe), 32'd0);
    check("rst_dat_out", 32'(bus.p1_dat_out), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
    check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(bus.req_ready), 32'd1);

    // stray XACK# while idle must not move the FSM
    flag = 0;
    bus.p1_xack_n = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.req_ready !== 1'b1 || !bus.p1_mrdc_n || !bus.p1_mrwc_n || bus.rsp_valid) flag = 1;
    end
    bus.p1_xack_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_xack_ignored", 32'(flag), 32'd0);

    for (int i = 0; i < 9; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 24; i++) begin
      v.write    = 1'($urandom);
      v.word     = 1'($urandom);
      v.addr     = 20'($urandom);
      v.wdata    = 16'($urandom);
      v.bus_data = 16'($urandom);
      v.d_ack    = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 12));
      v.h_rel    = int'($urandom_range(1, 6));
      v.exp_err = 2'd0; v.exp_rdata = '0; v.exp_dat = '0;
      v = model_result(v);
      run_vec(v, $sformatf("rnd%0d", i));
    end

    // reset in the middle of a strobe: strobes drop next clock, no completion
    bus.req_write = 1'b0;
    bus.req_word  = 1'b1;
    bus.req_addr  = 20'h00400;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    wait_c = 0;
    while (bus.p1_mrdc_n !== 1'b0 && wait_c < 20) begin
      @(negedge clk);
      wait_c++;
    end
    check("midrst_strobe_seen", 32'(bus.p1_mrdc_n), 32'd0);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_mrdc_n", 32'(bus.p1_mrdc_n), 32'd1);
    check("midrst_mrwc_n", 32'(bus.p1_mrwc_n), 32'd1);
    check("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("midrst_ready_in_reset", 32'(bus.req_ready), 32'd0);
    reset = 1'b0;
    flag = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b0 || !bus.p1_mrdc_n || !bus.p1_mrwc_n) flag = 1;
    end
    check("midrst_quiet_after", 32'(flag), 32'd0);
    check("midrst_ready_after", 32'(bus.req_ready), 32'd1);

    run_vec(tbl[0], "post_midrst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mbus_dvma_master.md
MBUS_DVMA_MASTER -- requirements
Module: mbus_dvma_master

Interface
REQ-001 SHALL have parameter T_SETUP, default 2, meaning clocks of address/data setup before command strobe.
REQ-002 SHALL have parameter T_HOLD, default 1, meaning clocks address/data held after strobe release.
REQ-003 SHALL have parameter T_TIMEOUT, default 255, meaning maximum strobe clocks awaiting XACK.
REQ-004 SHALL have port: clk  in  1  single clock, all logic on rising edge.
REQ-005 SHALL have port: reset  in  1  synchronous, active-high.
REQ-006 SHALL have ports: req_valid in 1, req_ready out 1; command handshake.
REQ-007 SHALL have ports: req_write in 1, req_word in 1, req_addr in 20, req_wdata in 16; command fields.
REQ-008 SHALL have ports: rsp_valid out 1, rsp_rdata out 16, rsp_err out 2; completion (0 ok, 1 timeout, 2 misaligned).
REQ-009 SHALL have ports: p1_adr out 20, p1_bhen_n out 1, p1_mrdc_n out 1, p1_mrwc_n out 1; Multibus address/command, active-low strobes.
REQ-010 SHALL have ports: p1_dat_out out 16, p1_dat_oe out 1, p1_dat_in in 16, p1_xack_n in 1 (asynchronous).

Function
REQ-011 SHALL implement states IDLE, SETUP, STROBE, HOLD, RESP.
REQ-012 req_ready SHALL be 1 only in IDLE; command accepted when req_valid and req_ready both 1.
REQ-013 On accept with req_word=1 and req_addr[0]=1, SHALL go to RESP with rsp_err=2 and assert no bus strobe.
REQ-014 On valid accept, SHALL register all command fields and drive p1_adr=req_addr, p1_bhen_n=~req_word, then enter SETUP.
REQ-015 Write data: word -> p1_dat_out=wdata; byte -> p1_dat_out={wdata[7:0],wdata[7:0]} (byte on D7-0 for even and odd, Multibus swap); p1_dat_oe=1 from SETUP through HOLD on writes only.
REQ-016 SETUP SHALL last exactly T_SETUP clocks, then STROBE.
REQ-017 In STROBE, p1_mrwc_n (write) or p1_mrdc_n (read) SHALL be 0; never both 0 in any cycle.
REQ-018 p1_xack_n SHALL pass a 2-flop synchronizer; STROBE exits to HOLD the clock after synchronized XACK is low.
REQ-019 Read data SHALL be captured from p1_dat_in on the STROBE exit edge; byte reads return {8'h00,p1_dat_in[7:0]}.
REQ-020 Strobe counter SHALL count STROBE clocks; reaching T_TIMEOUT without XACK SHALL exit to HOLD with rsp_err=1, rsp_rdata=0.
REQ-021 HOLD SHALL deassert strobe and last T_HOLD clocks, address/data unchanged, then RESP.
REQ-022 HOLD SHALL additionally wait until synchronized XACK is high before RESP (no overlapping cycles).
REQ-023 RESP SHALL assert rsp_valid for exactly one clock, then IDLE; rsp_rdata/rsp_err stable during that clock.
REQ-024 New command SHALL not be accepted in the RESP cycle (minimum one IDLE clock between cycles).
REQ-025 XACK low seen while not in STROBE SHALL be ignored (no state change).

Reset
REQ-026 Reset SHALL force IDLE; p1_mrdc_n=1, p1_mrwc_n=1, p1_bhen_n=1, p1_adr=0, p1_dat_oe=0, p1_dat_out=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=0 in reset cycle, counters and synchronizer flops cleared (sync to 1).
REQ-027 Reset mid-cycle SHALL release strobes in the next clock with no rsp_valid.

Structure
REQ-028 State encoding and rsp_err codes SHALL live in shared package mbus_pkg.
REQ-029 The XACK synchronizer SHALL be sub-module sync2 (reset value parameterized).

Verification
REQ-030 Word read 20'h01234, XACK after 3 strobe clocks, data 16'hBEEF -> p1_bhen_n=0, MRDC low 2 setup clocks after accept, rsp_rdata=16'hBEEF, rsp_err=0.
REQ-031 Byte write odd addr 20'h00011, wdata 16'h0055 -> p1_bhen_n=1, p1_dat_out=16'h5555, MRWC low, MRDC high throughout, rsp_err=0.
REQ-032 Word write addr 20'h00003 -> no strobe asserted, rsp_valid after 1 clock, rsp_err=2.
REQ-033 Read with XACK never asserted -> MRDC low exactly 255 clocks, rsp_err=1, rsp_rdata=0.
REQ-034 Slave holds XACK low 5 clocks after strobe release -> RESP delayed until XACK high; next command accepted only after.
REQ-035 Reset asserted during STROBE -> strobes high next clock, rsp_valid never pulses, req_ready=1 after reset.
